// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier: default field widths,
// operand classes, flag bit positions and the exponent bias helper.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  localparam int FLAGS_W       = 4;
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  typedef enum logic [2:0] {
    ZERO,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier: decodes exponent/fraction into a class and the
// significand with its hidden bit. Subnormals collapse to ZERO.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] frac_i,
  output fp_class_e        cls_o,
  output logic [MAN_W:0]   sig_o
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (exp_i == '0);
  assign exp_ones  = &exp_i;
  assign frac_zero = (frac_i == '0);

  always_comb begin
    cls_o = NORMAL;
    sig_o = {1'b1, frac_i};
    if (exp_zero) begin
      cls_o = ZERO;
      sig_o = '0;
    end else if (exp_ones) begin
      sig_o = '0;
      if (frac_zero) begin
        cls_o = INF;
      end else if (frac_i[MAN_W-1]) begin
        cls_o = QNAN;
      end else begin
        cls_o = SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-style multiplier (unpack, multiply, round/pack)
// with a single global advance enable for valid/ready backpressure.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FLAGS_W-1:0]       flags
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int SW      = MAN_W + 1;
  localparam int PW      = 2 * SW;
  localparam int XW      = EXP_W + 2;
  localparam int BIAS    = exp_bias(EXP_W);
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN_CANON = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  assign advance   = !s3_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;

  fp_class_e          cls_a, cls_b;
  logic [SW-1:0]      sig_a, sig_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp_i  (a[W-2 -: EXP_W]),
    .frac_i (a[MAN_W-1:0]),
    .cls_o  (cls_a),
    .sig_o  (sig_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp_i  (b[W-2 -: EXP_W]),
    .frac_i (b[MAN_W-1:0]),
    .cls_o  (cls_b),
    .sig_o  (sig_b)
  );

  // S1 registers
  logic               s1_sign_q;
  fp_class_e          s1_cls_a_q, s1_cls_b_q;
  logic [EXP_W-1:0]   s1_ea_q, s1_eb_q;
  logic [SW-1:0]      s1_siga_q, s1_sigb_q;

  // S2 combinational: product, exponent sum, special-case resolution
  logic [PW-1:0]        prod_d;
  logic signed [XW-1:0] exp_sum_d;
  logic                 nan_any, snan_any, inf_any, zero_any, inf_zero;
  logic                 spec_d;
  logic [W-1:0]         spec_res_d;
  logic [FLAGS_W-1:0]   spec_flg_d;

  assign prod_d    = PW'(s1_siga_q) * PW'(s1_sigb_q);
  assign exp_sum_d = XW'(s1_ea_q) + XW'(s1_eb_q) - XW'(BIAS);

  assign nan_any  = (s1_cls_a_q == QNAN) || (s1_cls_a_q == SNAN) ||
                    (s1_cls_b_q == QNAN) || (s1_cls_b_q == SNAN);
  assign snan_any = (s1_cls_a_q == SNAN) || (s1_cls_b_q == SNAN);
  assign inf_any  = (s1_cls_a_q == INF)  || (s1_cls_b_q == INF);
  assign zero_any = (s1_cls_a_q == ZERO) || (s1_cls_b_q == ZERO);
  assign inf_zero = inf_any && zero_any;

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = '0;
    spec_flg_d = '0;
    if (nan_any || inf_zero) begin
      spec_res_d              = QNAN_CANON;
      spec_flg_d[FLG_INVALID] = snan_any || inf_zero;
    end else if (inf_any) begin
      spec_res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_any) begin
      spec_res_d = {s1_sign_q, {(W-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // S2 registers
  logic                 s2_sign_q;
  logic [PW-1:0]        s2_prod_q;
  logic signed [XW-1:0] s2_exp_q;
  logic                 s2_spec_q;
  logic [W-1:0]         s2_spec_res_q;
  logic [FLAGS_W-1:0]   s2_spec_flg_q;

  // S3 combinational: normalise so the leading one sits just above norm's MSB
  logic                 msb;
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     frac;
  logic                 guard, rnd, sticky, rnd_up, inexact;
  logic [MAN_W+1:0]     sig_r;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_d;
  logic [FLAGS_W-1:0]   flg_d;

  assign msb     = s2_prod_q[PW-1];
  assign norm    = msb ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
  assign frac    = norm[PW-2 -: MAN_W];
  assign guard   = norm[PW-2-MAN_W];
  assign rnd     = norm[PW-3-MAN_W];
  assign sticky  = |norm[PW-4-MAN_W:0];
  assign rnd_up  = guard && (rnd || sticky || frac[0]);
  assign inexact = guard || rnd || sticky;
  assign sig_r   = {2'b01, frac} + {{(MAN_W+1){1'b0}}, rnd_up};
  assign frac_r  = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
  assign exp_r   = s2_exp_q + XW'(msb) + XW'(sig_r[MAN_W+1]);

  always_comb begin
    res_d              = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
    flg_d              = '0;
    flg_d[FLG_INEXACT] = inexact;
    if (s2_spec_q) begin
      res_d = s2_spec_res_q;
      flg_d = s2_spec_flg_q;
    end else if (int'(exp_r) >= EXP_MAX) begin
      res_d                = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d                = '0;
      flg_d[FLG_OVERFLOW]  = 1'b1;
      flg_d[FLG_INEXACT]   = 1'b1;
    end else if (int'(exp_r) < 1) begin
      res_d                = {s2_sign_q, {(W-1){1'b0}}};
      flg_d                = '0;
      flg_d[FLG_UNDERFLOW] = 1'b1;
      flg_d[FLG_INEXACT]   = 1'b1;
    end
  end

  logic [W-1:0]       result_q;
  logic [FLAGS_W-1:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        result_q <= res_d;
        flags_q  <= flg_d;
      end
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign_q     <= a[W-1] ^ b[W-1];
      s1_cls_a_q    <= cls_a;
      s1_cls_b_q    <= cls_b;
      s1_ea_q       <= a[W-2 -: EXP_W];
      s1_eb_q       <= b[W-2 -: EXP_W];
      s1_siga_q     <= sig_a;
      s1_sigb_q     <= sig_b;
      s2_sign_q     <= s1_sign_q;
      s2_prod_q     <= prod_d;
      s2_exp_q      <= exp_sum_d;
      s2_spec_q     <= spec_d;
      s2_spec_res_q <= spec_res_d;
      s2_spec_flg_q <= spec_flg_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single-precision instance plus a
// half-precision (5/10) instance with its own reset.
module tb_fp_mul_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  logic        clk, rst_n, rst_n_h;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, result_h;
  logic [3:0]  flags_h;

  int total = 0;
  int bad   = 0;

  logic [35:0] exp_q[$];
  logic [19:0] exp_qh[$];
  logic [35:0] mon_e;
  logic [19:0] mon_eh;
  logic [35:0] held;
  logic        held_v = 1'b0;

  vec_t vecs [14] = '{
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
    '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
    '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000},
    '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
    '{32'h3FC00003, 32'h3FAAAAA8, 32'h40000000, 4'b0001},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000},
    '{32'hFFC00001, 32'h40000000, 32'h7FC00000, 4'b0000},
    '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000},
    '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000},
    '{32'hC0400000, 32'h40800000, 32'hC1400000, 4'b0000},
    '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000}
  };

  logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] bp_r [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                            32'h41000000, 32'h41200000, 32'h41400000};

  fp_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk       (clk),
    .rst_n     (rst_n_h),
    .in_valid  (in_valid_h),
    .in_ready  (in_ready_h),
    .a         (a_h),
    .b         (b_h),
    .out_valid (out_valid_h),
    .out_ready (out_ready_h),
    .result    (result_h),
    .flags     (flags_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic [31:0] er, input logic [3:0] ef);
    int n = 0;
    a = ta; b = tb; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stuck low for a=%h", ta);
    end else begin
      exp_q.push_back({er, ef});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_h(input logic [15:0] ta, input logic [15:0] tb,
                        input logic [15:0] er, input logic [3:0] ef, input bit push);
    int n = 0;
    a_h = ta; b_h = tb; in_valid_h = 1'b1;
    #1;
    while (!in_ready_h && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready_h) begin
      total++; bad++;
      $display("FAIL send_h_timeout: in_ready stuck low for a=%h", ta);
    end else if (push) begin
      exp_qh.push_back({er, ef});
    end
    @(negedge clk);
    in_valid_h = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (!out_ready) begin
        if (held_v) chk("stall_hold", 64'({result, flags}), 64'(held));
        held   = {result, flags};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %h with nothing outstanding", result);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", 64'(result), 64'(mon_e[35:4]));
          chk("flags", 64'(flags), 64'(mon_e[3:0]));
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n_h && out_valid_h && out_ready_h) begin
      if (exp_qh.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out_h: got %h with nothing outstanding", result_h);
      end else begin
        mon_eh = exp_qh.pop_front();
        chk("result_h", 64'(result_h), 64'(mon_eh[19:4]));
        chk("flags_h", 64'(flags_h), 64'(mon_eh[3:0]));
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; rst_n_h = 1'b0;
    in_valid = 1'b0; in_valid_h = 1'b0;
    out_ready = 1'b1; out_ready_h = 1'b1;
    a = '0; b = '0; a_h = '0; b_h = '0;
    repeat (3) @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_valid_h", 64'(out_valid_h), 64'h0);
    chk("rst_result_h", 64'(result_h), 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1; rst_n_h = 1'b1;
    @(negedge clk);

    // Latency: visible in the third cycle after the accepting cycle.
    send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    #1 chk("lat_c1", 64'(out_valid), 64'h0);
    @(negedge clk); #1 chk("lat_c2", 64'(out_valid), 64'h0);
    @(negedge clk); #1 chk("lat_c3", 64'(out_valid), 64'h1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) send(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end

    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_a[i], 32'h40000000, bp_r[i], 4'b0000);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          if (c == 2) out_ready = 1'b0;
          if (c == 9) out_ready = 1'b1;
          if (c == 5) begin
            #1 chk("in_ready_full", 64'(in_ready), 64'h0);
          end
          @(negedge clk);
        end
      end
    join

    // Half-precision: reset with two ops in flight, then fresh traffic.
    send_h(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 1'b0);
    send_h(16'h4000, 16'h4000, 16'h4400, 4'b0000, 1'b0);
    rst_n_h = 1'b0;
    #1;
    chk("rst_mid_out_valid_h", 64'(out_valid_h), 64'h0);
    chk("rst_mid_in_ready_h", 64'(in_ready_h), 64'h1);
    chk("rst_mid_result_h", 64'(result_h), 64'h0);
    repeat (2) @(negedge clk);
    rst_n_h = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 chk("post_rst_idle_h", 64'(out_valid_h), 64'h0);
    end
    @(negedge clk);
    send_h(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 1'b1);
    send_h(16'h3C00, 16'hBC00, 16'hBC00, 4'b0000, 1'b1);
    send_h(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || exp_qh.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    total++;
    if (exp_q.size() != 0 || exp_qh.size() != 0) begin
      bad++;
      $display("FAIL drain: outstanding %0d/%0d want 0/0", exp_q.size(), exp_qh.size());
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter MAN_W, default 23: stored fraction width; operand and result width is 1+EXP_W+MAN_W (32 by default).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 a, b  input  1+EXP_W+MAN_W each  IEEE-style operands: sign, biased exponent, fraction.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 result  output  1+EXP_W+MAN_W  rounded product.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-012 Transfers SHALL occur on in_valid&in_ready (input) and on out_valid&out_ready (output).
REQ-013 The pipeline SHALL have 3 register stages: S1 unpack/classify, S2 full (MAN_W+1)x(MAN_W+1) product plus exponent sum, S3 normalise/round/pack.
REQ-014 Latency SHALL be 3 cycles from an input transfer to out_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-015 The advance enable SHALL be (!out_valid | out_ready); in_ready SHALL equal the advance enable; all stages hold on a stall; no result is dropped or duplicated, and results leave in input order.
REQ-016 Each stage SHALL carry a valid bit; bubbles propagate without asserting out_valid.
REQ-017 Result sign SHALL be sign_a XOR sign_b for every class, except NaN.
REQ-018 Biased exponent arithmetic SHALL use EXP_W+2 signed bits: ea+eb-bias, +1 when the product MSB is set; bias = 2^(EXP_W-1)-1.
REQ-019 Rounding SHALL be round-to-nearest-even using guard, round and sticky (OR of all discarded bits).
REQ-020 Renormalisation SHALL apply when rounding carries out of the significand, with the exponent incremented.
REQ-021 Subnormal inputs (exp=0, fraction!=0) SHALL be treated as signed zero, with no flag.
REQ-022 Special cases:
 - NaN input, or inf x 0: canonical NaN (sign 0, exp all ones, fraction MSB 1, rest 0); invalid=1 only for inf x 0 and for signalling NaN (fraction MSB 0).
 - inf x nonzero finite, or inf x inf: signed infinity, no flags.
 - zero x finite: signed zero, no flags.
REQ-023 Overflow (rounded exponent >= all-ones): signed infinity, overflow=1, inexact=1.
REQ-024 Underflow (nonzero result, rounded exponent < 1): flush to signed zero, underflow=1, inexact=1.
REQ-025 Otherwise inexact SHALL equal guard|round|sticky.
REQ-026 result and flags SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While rst_n=0: all stage valid bits, out_valid, result and flags SHALL be 0.
REQ-028 While rst_n=0: in_ready SHALL be 1.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; the first valid output after release SHALL come from an input accepted after release.
REQ-030 Datapath registers other than result and flags need no reset.

Structure
REQ-031 A shared package fp_pkg SHALL hold default EXP_W/MAN_W, the bias function, the operand class enumeration (ZERO, NORMAL, INF, QNAN, SNAN) and flag bit indices.
REQ-032 Classification SHALL be one sub-module, fp_classify, instantiated once per operand in S1.
REQ-033 fp_classify SHALL output the class and the significand with hidden bit.
REQ-034 All widths SHALL derive from EXP_W/MAN_W; no literal 8, 23, 24 or 48 in RTL.

Verification (default parameters unless stated)
REQ-035 a=0x3FC00000, b=0x40000000, out_ready=1 -> result 0x40400000, flags 0000, out_valid exactly 3 cycles after acceptance.
REQ-036 a=0x3F800001, b=0x3F800001 -> result 0x3F800002, inexact only (RNE, sticky).
REQ-037 a=0x7F800000, b=0x00000000 -> 0x7FC00000, invalid only; a=0x7F7FFFFF, b=0x40000000 -> 0x7F800000, overflow+inexact.
REQ-038 a=0x00800000, b=0x3F000000 -> 0x00000000, underflow+inexact; a=0x80000000, b=0x40000000 -> 0x80000000, flags 0000.
REQ-039 Backpressure: issue 6 back-to-back ops with out_ready=0 for cycles 2..8 -> in_ready low while the pipe is full, all 6 results delivered in order, held values stable during stall.
REQ-040 Parameter variant EXP_W=5, MAN_W=10: a=0x3E00, b=0x4000 -> 0x4200; assert rst_n low with 2 ops in flight -> no output after release until new input.
